// File: rtl/top.sv
// top: sequential radix-4 Booth multiplier, 8b signed x 4b signed, one result every 4 cycles
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   multiplicand  signed operand A (8b), sampled on the LOAD edge
//   multiplier    signed operand B (4b), sampled on the LOAD edge
//   product       registered P[7:0] of A*B, updated on the DONE edge
//   cout          registered P[8] of A*B, updated on the DONE edge
module top (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic [7:0] product,
  output logic       cout
);
  typedef enum logic [1:0] {LOAD, STEP0, STEP1, DONE} state_t;
  state_t state, state_nx;
  logic [11:0] a, acc, pp;
  logic [4:0] q;
  logic is_load, is_step, is_done;
  always_ff @(posedge clk)
    state <= rst ? LOAD : state_nx;
  always_comb
    state_nx = state == LOAD ? STEP0 : state == STEP0 ? STEP1 : state == STEP1 ? DONE : LOAD;
  // a is kept 12 bits wide so that 2A and the shifted 4A of multiplicand = -128 stay exact
  always_comb begin
    is_load = state == LOAD;
    is_step = state == STEP0 || state == STEP1;
    is_done = state == DONE;
    pp = q[2:0] == 3'b001 || q[2:0] == 3'b010 ? a :
         q[2:0] == 3'b011 ? a << 1 :
         q[2:0] == 3'b100 ? -(a << 1) :
         q[2:0] == 3'b101 || q[2:0] == 3'b110 ? -a : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      a <= '0;
      q <= '0;
      acc <= '0;
      product <= '0;
      cout <= 1'b0;
    end else begin
      if (is_load) begin
        a <= {{4{multiplicand[7]}}, multiplicand};
        q <= {multiplier, 1'b0};
        acc <= '0;
      end
      if (is_step) begin
        acc <= acc + pp;
        a <= a << 2;
        q <= {{2{q[4]}}, q[4:2]};
      end
      if (is_done) begin
        product <= acc[7:0];
        cout <= acc[8];
      end
    end
endmodule

// File: tb/tb_top.sv
// tb_top: scoreboard bench for the Booth multiplier top
module tb_top;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] multiplicand;
  logic [3:0] multiplier;
  logic [7:0] product;
  logic cout;
  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last;
  top dut (
    .clk(clk),
    .rst(rst),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .product(product),
    .cout(cout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {cout,product}=%h expected %h", tag, got, exp);
    end
  endtask
  // entered at a negedge one half-cycle before a LOAD edge; leaves at the next such negedge
  task automatic run_op(input string tag, input logic [7:0] av, input logic [3:0] bv, input bit scramble);
    logic [11:0] p;
    logic [8:0] e;
    multiplicand = av;
    multiplier = bv;
    p = $signed(av) * $signed(bv);
    exp_q.push_back({p[8], p[7:0]});
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (scramble) begin
        multiplicand = 8'($urandom);
        multiplier = 4'($urandom);
      end
      chk({tag, "_hold"}, {cout, product}, last);
      @(posedge clk);
    end
    #1;
    if (exp_q.size() == 0) chk({tag, "_empty"}, 9'h1ff, 9'h000);
    else begin
      e = exp_q.pop_front();
      chk(tag, {cout, product}, e);
      last = e;
    end
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    multiplicand = 8'h5a;
    multiplier = 4'h3;
    last = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("reset", {cout, product}, 9'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("neg6x6", 8'hfa, 4'h6, 1'b0);
    run_op("7x3", 8'h07, 4'h3, 1'b0);
    run_op("7fxm8", 8'h7f, 4'h8, 1'b0);
    run_op("80xm8", 8'h80, 4'h8, 1'b0);
    run_op("5xm1_scr", 8'h05, 4'hf, 1'b1);
    run_op("80x7", 8'h80, 4'h7, 1'b0);
    run_op("7fx7", 8'h7f, 4'h7, 1'b1);
    for (int i = 0; i < 20; i++)
      run_op("rand", 8'($urandom), 4'($urandom), i[0]);
    run_op("pre_rst", 8'h11, 4'h5, 1'b0);
    multiplicand = 8'h33;
    multiplier = 4'h5;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("mid_rst", {cout, product}, 9'h000);
    last = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 8'hfa, 4'h6, 1'b0);
    run_op("post_rst2", 8'h07, 4'h3, 1'b1);
    chk("queue_empty", 9'(exp_q.size()), 9'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning); clock and reset are listed first.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 multiplicand  input  8  signed two's-complement operand A.
REQ-005 multiplier  input  4  signed two's-complement operand B.
REQ-006 product  output  8  registered bits [7:0] of the signed product A*B.
REQ-007 cout  output  1  registered bit [8] of the two's-complement product A*B.
REQ-008 The block SHALL have no parameters; all widths are fixed as listed above.

Function
REQ-009 The block SHALL be a sequential radix-4 (3-bit-group) Booth multiplier computing the exact signed 12-bit product P = A*B.
REQ-010 The FSM SHALL cycle LOAD -> STEP0 -> STEP1 -> DONE -> LOAD continuously while rst=0, with no start/valid handshake.
REQ-011 In LOAD, the block SHALL do the following:
- capture A sign-extended to 12 bits;
- capture Q = {multiplier, 1'b0} (5 bits);
- clear the 12-bit accumulator.
REQ-012 In each STEP state, the block SHALL select a partial product from Q[2:0]:
- 000 or 111: 0;
- 001 or 010: +A;
- 011: +2A;
- 100: -2A;
- 101 or 110: -A.
REQ-013 In each STEP state, the block SHALL add the selected partial product to the accumulator (mod 2^12), then shift the A register left by 2 and Q right by 2 arithmetically.
REQ-014 In DONE, the block SHALL load product <= acc[7:0] and cout <= acc[8].
REQ-015 product and cout SHALL hold their values between DONE updates.
REQ-016 Latency SHALL be fixed: operands are sampled at the LOAD edge, and outputs update 3 rising edges later (the DONE edge). A new result appears every 4 cycles.
REQ-017 Operand changes outside the LOAD edge SHALL NOT affect the computation in progress.
REQ-018 Overflow rule: bits [11:9] of P SHALL be discarded; there is no saturation and no overflow flag.
REQ-019 Boundary behaviour SHALL be as follows:
- multiplier = -8 (1000) SHALL be handled via the -2A group in STEP1;
- multiplicand = -128 SHALL be handled correctly by the 12-bit sign extension of A and 2A.

Reset
REQ-020 When rst=1 at a rising edge, the block SHALL set product=8'h00, cout=0, clear the internal registers, and force the state to LOAD.
REQ-021 While rst is held at 1, the outputs SHALL remain 0.
REQ-022 The first LOAD edge SHALL be the first rising edge with rst=0.
REQ-023 Reset asserted in any state, including mid-computation, SHALL abort the operation with no output update. That result SHALL never appear.

Verification
REQ-024 A=8'hFA (-6), B=4'h6, rst=0 -> after 4 edges: product=8'hDC, cout=1 (P=-36).
REQ-025 A=8'h07, B=4'h3 -> product=8'h15, cout=0 (P=21).
REQ-026 A=8'h7F, B=4'h8 (-8) -> product=8'h08, cout=0 (P=-1016=12'hC08).
REQ-027 A=8'h80, B=4'h8 -> product=8'h00, cout=0 (P=1024=12'h400).
REQ-028 A=8'h05, B=4'hF (-1) -> product=8'hFB, cout=1. Changing the operands during STEP0/STEP1 SHALL NOT alter this result.
REQ-029 Mid-operation reset: assert rst for 1 cycle during STEP1 -> product=8'h00, cout=0 immediately. The next valid result SHALL appear 4 edges after rst falls.
